// File: rtl/sram_ctrl.sv
// sram_ctrl: data-side memory responder for the CPU data port.
//
// Accepts one load or store at a time from the CPU and runs it against an external
// asynchronous 32-bit SRAM with programmable read wait states and write pulse width.
// Every SRAM strobe is driven from a flop, so the pins are glitch-free.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ram_addr_i            byte address from the CPU; bits [ADDR_W+1:2] select the word
//   ram_data_i            store data
//   ram_re_i, ram_we_i    load / store request, held by the CPU until ready_o
//   ram_mask_i            store byte enables, active-high
//   ram_data_o            load data, held until the next load completes
//   ready_o               one-cycle completion pulse
//   stall_o               (re|we) & ~ready_o, combinational
//   sram_addr_o           SRAM word address
//   sram_dq_i/_o/_oe_o    SRAM data bus read path, write path and output enable
//   sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o   active-low SRAM strobes
//
// Configuration:
//   SRAM_CTRL_RDBUF_EN    when defined, adds a 1-entry read buffer (valid, word address,
//                         data). A load that hits completes in one cycle without touching
//                         the SRAM; a store to the buffered word invalidates it.

module sram_ctrl #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned WR_PULSE = 2
) (
  input  logic              clk,
  input  logic              rst,
  // CPU data port
  input  logic [31:0]       ram_addr_i,
  input  logic [31:0]       ram_data_i,
  input  logic              ram_re_i,
  input  logic              ram_we_i,
  input  logic [3:0]        ram_mask_i,
  output logic [31:0]       ram_data_o,
  output logic              ready_o,
  output logic              stall_o,
  // SRAM pins
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [31:0]       sram_dq_i,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  localparam int unsigned MaxWait = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int unsigned CntW    = $clog2(MaxWait) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdDone,
    StWrSetup,
    StWrPulse,
    StWrHold
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       ram_data_q, ram_data_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]       sram_dq_q, sram_dq_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [3:0]        be_n_q, be_n_d;

  logic [ADDR_W-1:0] req_addr;
  logic              buf_hit;
  logic [31:0]       buf_rdata;
  logic              rd_last;

  assign req_addr = ram_addr_i[ADDR_W+1:2];
  assign rd_last  = (state_q == StRd) && (cnt_q == '0);

  // Byte-lane bits and the upper address bits beyond the SRAM are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{ram_addr_i[31:ADDR_W+2], ram_addr_i[1:0]};

`ifdef SRAM_CTRL_RDBUF_EN
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [31:0]       buf_data_q, buf_data_d;

  assign buf_hit   = buf_valid_q && (buf_addr_q == req_addr);
  assign buf_rdata = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if ((state_q == StIdle) && ram_we_i && buf_hit) begin
      // Store accepted to the buffered word: the copy is now stale.
      buf_valid_d = 1'b0;
    end else if (rd_last) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = sram_addr_q;
      buf_data_d  = sram_dq_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign buf_hit   = 1'b0;
  assign buf_rdata = '0;
`endif

  // Next-state and next-output logic. Outputs are computed for the state being entered,
  // so every pin comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_data_d  = ram_data_q;
    ready_d     = 1'b0;
    sram_addr_d = sram_addr_q;
    sram_dq_d   = sram_dq_q;
    dq_oe_d     = dq_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    be_n_d      = be_n_q;

    unique case (state_q)
      StIdle: begin
        if (ram_we_i) begin
          // Store wins when re and we are both raised; the load is dropped.
          state_d     = StWrSetup;
          sram_addr_d = req_addr;
          sram_dq_d   = ram_data_i;
          be_n_d      = ~ram_mask_i;
          ce_n_d      = 1'b0;
          oe_n_d      = 1'b1;
          we_n_d      = 1'b1;
          dq_oe_d     = 1'b1;
        end else if (ram_re_i && buf_hit) begin
          state_d    = StRdDone;
          ram_data_d = buf_rdata;
          ready_d    = 1'b1;
        end else if (ram_re_i) begin
          state_d     = StRd;
          cnt_d       = CntW'(RD_WAIT - 1);
          sram_addr_d = req_addr;
          be_n_d      = 4'b0000;
          ce_n_d      = 1'b0;
          oe_n_d      = 1'b0;
          dq_oe_d     = 1'b0;
        end
      end

      StRd: begin
        if (cnt_q == '0) begin
          state_d    = StRdDone;
          ram_data_d = sram_dq_i;
          ready_d    = 1'b1;
          ce_n_d     = 1'b1;
          oe_n_d     = 1'b1;
          be_n_d     = 4'b1111;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StRdDone: begin
        state_d = StIdle;
      end

      StWrSetup: begin
        state_d = StWrPulse;
        cnt_d   = CntW'(WR_PULSE - 1);
        we_n_d  = 1'b0;
      end

      StWrPulse: begin
        if (cnt_q == '0) begin
          // we_n rises while address, data and ce_n stay put: SRAM latches here.
          state_d = StWrHold;
          we_n_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StWrHold: begin
        state_d = StIdle;
        ce_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        be_n_d  = 4'b1111;
      end

      default: begin
        state_d = StIdle;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        be_n_d  = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ram_data_q  <= '0;
      ready_q     <= 1'b0;
      sram_addr_q <= '0;
      sram_dq_q   <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 4'b1111;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_data_q  <= ram_data_d;
      ready_q     <= ready_d;
      sram_addr_q <= sram_addr_d;
      sram_dq_q   <= sram_dq_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
    end
  end

  assign ram_data_o   = ram_data_q;
  assign ready_o      = ready_q;
  assign stall_o      = (ram_re_i | ram_we_i) & ~ready_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_dq_o    = sram_dq_q;
  assign sram_dq_oe_o = dq_oe_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_be_n_o  = be_n_q;

endmodule
